// File: rtl/mxint_accumulator.sv
// Element-wise accumulator of IN_DEPTH MxInt blocks into one wide, un-normalized MxInt block.
// Optional build macro MXINT_ACC_ROUND_EN: alignment shifts round to nearest (ties up) instead of truncating.
module mxint_accumulator #(
    parameter int IN_MAN_WIDTH  = 8,
    parameter int IN_EXP_WIDTH  = 4,
    parameter int BLOCK_SIZE    = 2,
    parameter int IN_DEPTH      = 4,
    localparam int ACC_MAN_WIDTH = IN_MAN_WIDTH + $clog2(IN_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
    input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic signed [ACC_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic        [IN_EXP_WIDTH-1:0]  edata_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready
);

    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    // Shift x right by d exponent steps toward a larger shared exponent.
    function automatic logic signed [ACC_MAN_WIDTH-1:0] f_align(
        input logic signed [ACC_MAN_WIDTH-1:0] x,
        input logic        [IN_EXP_WIDTH-1:0]  d
    );
`ifdef MXINT_ACC_ROUND_EN
        logic signed [ACC_MAN_WIDTH:0] v_bias;
        logic signed [ACC_MAN_WIDTH:0] v_wide;
        logic signed [ACC_MAN_WIDTH:0] v_shift;
        f_align = '0;
        v_bias  = '0;
        v_wide  = '0;
        v_shift = '0;
        if (d == '0) begin
            f_align = x;
        end else if (32'(d) < ACC_MAN_WIDTH) begin
            // One extra bit keeps x + half-LSB from wrapping at full scale.
            v_bias  = (ACC_MAN_WIDTH + 1)'(1) << (d - IN_EXP_WIDTH'(1));
            v_wide  = (ACC_MAN_WIDTH + 1)'(x) + v_bias;
            v_shift = v_wide >>> d;
            f_align = v_shift[ACC_MAN_WIDTH-1:0];
        end
`else
        if (32'(d) >= ACC_MAN_WIDTH) begin
            f_align = {ACC_MAN_WIDTH{x[ACC_MAN_WIDTH-1]}};
        end else begin
            f_align = x >>> d;
        end
`endif
    endfunction

    logic        [CNT_W-1:0]         r_count;
    logic        [IN_EXP_WIDTH-1:0]  r_exp;
    logic signed [ACC_MAN_WIDTH-1:0] r_acc [BLOCK_SIZE];
    logic signed [ACC_MAN_WIDTH-1:0] r_mdata_out [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0]  r_edata_out;
    logic                            r_out_valid;

    logic                            w_in_ready;
    logic                            w_accept;
    logic                            w_first;
    logic                            w_last;
    logic                            w_exp_gt;
    logic        [IN_EXP_WIDTH-1:0]  w_diff;
    logic        [IN_EXP_WIDTH-1:0]  w_exp_next;
    logic signed [ACC_MAN_WIDTH-1:0] w_ext [BLOCK_SIZE];
    logic signed [ACC_MAN_WIDTH-1:0] w_sum [BLOCK_SIZE];

    assign w_in_ready = !r_out_valid || data_out_ready;
    assign w_accept   = data_in_valid && w_in_ready;
    assign w_first    = (r_count == '0);
    assign w_last     = (r_count == LAST_CNT);
    assign w_exp_gt   = (edata_in > r_exp);
    assign w_diff     = w_exp_gt ? (edata_in - r_exp) : (r_exp - edata_in);
    assign w_exp_next = (w_first || w_exp_gt) ? edata_in : r_exp;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_ext[i] = ACC_MAN_WIDTH'(mdata_in[i]);
            w_sum[i] = w_ext[i];
            if (!w_first) begin
                if (w_exp_gt) begin
                    w_sum[i] = f_align(r_acc[i], w_diff) + w_ext[i];
                end else begin
                    w_sum[i] = r_acc[i] + f_align(w_ext[i], w_diff);
                end
            end
        end
    end

    // NOTE: the lane array is a handful of flops, not a RAM, so it is cleared by reset with everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_exp       <= '0;
            r_edata_out <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_acc[i]       <= '0;
                r_mdata_out[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                r_exp <= w_exp_next;
                if (w_last) begin
                    r_count     <= '0;
                    r_mdata_out <= w_sum;
                    r_edata_out <= w_exp_next;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            // A completing beat wins over a same-cycle output handshake.
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign data_in_ready  = w_in_ready;
    assign data_out_valid = r_out_valid;
    assign mdata_out      = r_mdata_out;
    assign edata_out      = r_edata_out;

endmodule

// File: tb/tb_mxint_accumulator.sv
// Self-checking bench for mxint_accumulator: arithmetic block model plus directed vectors.
// Honors MXINT_ACC_ROUND_EN for the rounding build.
module tb_mxint_accumulator;

    localparam int IN_MAN_WIDTH = 8;
    localparam int IN_EXP_WIDTH = 4;
    localparam int BLOCK_SIZE   = 2;
    localparam int IN_DEPTH     = 4;
    localparam int ACC_W        = 10;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic signed [IN_MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0] edata_in = '0;
    logic                           data_in_valid = 1'b0;
    logic                           data_in_ready;
    logic signed [ACC_W-1:0]        mdata_out [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0] edata_out;
    logic                           data_out_valid;
    logic                           data_out_ready = 1'b1;

    mxint_accumulator #(
        .IN_MAN_WIDTH(IN_MAN_WIDTH),
        .IN_EXP_WIDTH(IN_EXP_WIDTH),
        .BLOCK_SIZE  (BLOCK_SIZE),
        .IN_DEPTH    (IN_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mdata_in      (mdata_in),
        .edata_in      (edata_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .mdata_out     (mdata_out),
        .edata_out     (edata_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int m0;
        int m1;
        int e;
    } blk_t;

    blk_t exp_q[$];
    int   m_cnt = 0;
    int   m_acc0 = 0;
    int   m_acc1 = 0;
    int   m_exp = 0;

    function automatic int floor_div(input int x, input int p);
        int q;
        q = x / p;
        if ((x % p != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // Value of x expressed against an exponent d steps larger.
    function automatic int model_align(input int x, input int d);
        if (d == 0) return x;
`ifdef MXINT_ACC_ROUND_EN
        if (d >= ACC_W) return 0;
        return floor_div(x + (2 ** (d - 1)), 2 ** d);
`else
        if (d >= ACC_W) return (x < 0) ? -1 : 0;
        return floor_div(x, 2 ** d);
`endif
    endfunction

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        int i0, i1, ie, d;
        if (!rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = !exp_valid || data_out_ready;
            check("out_valid", 32'(data_out_valid), 32'(exp_valid));
            check("in_ready", 32'(data_in_ready), 32'(exp_ready));
            if (exp_valid) begin
                check("out_m0", 32'(mdata_out[0]), exp_q[0].m0);
                check("out_m1", 32'(mdata_out[1]), exp_q[0].m1);
                check("out_e", 32'(edata_out), exp_q[0].e);
                if (data_out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            if (data_in_valid && exp_ready) begin
                i0 = int'(mdata_in[0]);
                i1 = int'(mdata_in[1]);
                ie = int'(edata_in);
                if (m_cnt == 0) begin
                    m_acc0 = i0;
                    m_acc1 = i1;
                    m_exp  = ie;
                end else if (ie > m_exp) begin
                    d      = ie - m_exp;
                    m_acc0 = model_align(m_acc0, d) + i0;
                    m_acc1 = model_align(m_acc1, d) + i1;
                    m_exp  = ie;
                end else begin
                    d      = m_exp - ie;
                    m_acc0 = m_acc0 + model_align(i0, d);
                    m_acc1 = m_acc1 + model_align(i1, d);
                end
                m_cnt++;
                if (m_cnt == IN_DEPTH) begin
                    exp_q.push_back('{m0: m_acc0, m1: m_acc1, e: m_exp});
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input int m0, input int m1, input int e);
        int waited = 0;
        mdata_in[0]   = IN_MAN_WIDTH'(m0);
        mdata_in[1]   = IN_MAN_WIDTH'(m1);
        edata_in      = IN_EXP_WIDTH'(e);
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!data_in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: data_in_ready stayed 0 for %0d cycles, expected 1", waited);
            data_in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t0;
        int     n0;
        mdata_in[0] = '0;
        mdata_in[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(data_out_valid), 0);
        check("rst_m0", 32'(mdata_out[0]), 0);
        check("rst_m1", 32'(mdata_out[1]), 0);
        check("rst_e", 32'(edata_out), 0);
        check("rst_in_ready", 32'(data_in_ready), 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: equal exponents, latency of one cycle after the last beat
        repeat (3) send_beat(10, -3, 7);
        check("t1_valid_before_last", 32'(data_out_valid), 0);
        send_beat(10, -3, 7);
        idle();
        check("t1_valid_latency", 32'(data_out_valid), 1);
        check("t1_m0", 32'(mdata_out[0]), 40);
        check("t1_m1", 32'(mdata_out[1]), -12);
        check("t1_e", 32'(edata_out), 7);
        @(posedge clk);
        #1;

        // 2: rising exponents with realignment
        send_beat(64, -64, 5);
        send_beat(16, 16, 7);
        send_beat(8, 8, 6);
        send_beat(0, 0, 7);
        idle();
        check("t2_m0", 32'(mdata_out[0]), 36);
        check("t2_m1", 32'(mdata_out[1]), 4);
        check("t2_e", 32'(edata_out), 7);
        @(posedge clk);
        #1;

        // 3: backpressure holds outputs and stalls input
        data_out_ready = 1'b0;
        repeat (4) send_beat(3, -2, 2);
        idle();
        repeat (5) begin
            @(negedge clk);
            check("t3_in_ready", 32'(data_in_ready), 0);
            check("t3_valid", 32'(data_out_valid), 1);
            check("t3_m0", 32'(mdata_out[0]), 12);
            check("t3_m1", 32'(mdata_out[1]), -8);
            check("t3_e", 32'(edata_out), 2);
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_released", 32'(data_out_valid), 0);

        // 4: streaming, one beat per cycle for 12 cycles
        n0 = n_out;
        t0 = $time;
        for (int k = 0; k < 12; k++) begin
            send_beat(10 * k - 50, 7 - 3 * k, (k * 5) % 16);
        end
        check("t4_cycles", 32'(($time - t0) / 10), 12);
        idle();
        repeat (3) @(negedge clk);
        check("t4_blocks", n_out - n0, 3);
        @(posedge clk);
        #1;

        // 5: reset mid-block discards the partial sum
        send_beat(9, 9, 5);
        send_beat(9, 9, 5);
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", 32'(data_out_valid), 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) send_beat(1, 1, 3);
        idle();
        check("t5_m0", 32'(mdata_out[0]), 4);
        check("t5_m1", 32'(mdata_out[1]), 4);
        check("t5_e", 32'(edata_out), 3);
        @(posedge clk);
        #1;

        // 6: exponent gap beyond the accumulator width
        send_beat(-1, 5, 0);
        repeat (3) send_beat(0, 0, 15);
        idle();
`ifdef MXINT_ACC_ROUND_EN
        check("t6_m0", 32'(mdata_out[0]), 0);
`else
        check("t6_m0", 32'(mdata_out[0]), -1);
`endif
        check("t6_m1", 32'(mdata_out[1]), 0);
        check("t6_e", 32'(edata_out), 15);
        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
